mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter MAX_WAIT, default 255, SHALL set the bus-wait cycle limit per memory access before timeout (range 1..255).
REQ-002 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 ex_valid  input  1  SHALL mark an operation present from the EX/MEM register.
REQ-005 ex_is_load, ex_is_store  input  1 each  SHALL be the operation type; both 0 means ALU pass-through.
REQ-006 ex_funct3  input  3  SHALL be the RV32I load/store size code.
REQ-007 ex_addr, ex_wdata, ex_pc  input  32 each  SHALL be the ALU result/address, the rs2 store data and the instruction PC.
REQ-008 stall_o  output  1  SHALL request that upstream hold its register.
REQ-009 dmem_req, dmem_we  output  1 each; dmem_addr, dmem_wdata  output  32 each; dmem_be  output  4  SHALL form the memory request.
REQ-010 dmem_gnt, dmem_rvalid  input  1 each; dmem_rdata  input  32  SHALL be the request grant, the read-response strobe and the read data.
REQ-011 wb_valid  output  1; wb_data, wb_pc  output  32 each  SHALL form the write-back result.
REQ-012 fault  output  1; fault_pc  output  32; fault_cause  output  2 (01 misaligned, 10 illegal funct3, 11 timeout)  SHALL report access errors.

Function
REQ-013 The FSM SHALL have the states IDLE, REQ and RSP; stall_o SHALL equal (state != IDLE).
REQ-014 In IDLE, an operation is accepted when ex_valid=1; it SHALL NOT be accepted in any other state.
REQ-015 Pass-through: the cycle after acceptance, wb_valid=1, wb_data=ex_addr and wb_pc=ex_pc; this path has 1-cycle latency and no stall.
REQ-016 Legal funct3: load 000/001/010/100/101; store 000/001/010. Any other code SHALL produce fault with cause 10 and SHALL NOT produce a bus request.
REQ-017 Misalignment (halfword with addr[0]=1; word with addr[1:0]!=00) SHALL produce fault with cause 01 and SHALL NOT produce a bus request.
REQ-018 For each fault: fault SHALL be a single-cycle pulse in the cycle after acceptance, fault_pc SHALL be the captured PC, the FSM SHALL stay in IDLE, and wb_valid SHALL stay 0.
REQ-019 On a legal memory operation the block SHALL capture addr, data, funct3 and PC, and the FSM SHALL go IDLE->REQ.
REQ-020 In REQ: dmem_req=1; dmem_addr={addr[31:2],2'b00}; dmem_we=store; request fields SHALL be held stable until dmem_gnt=1.
REQ-021 Byte enables: byte = 0001<<addr[1:0]; half = 0011<<{addr[1],1'b0}; word = 1111. dmem_wdata SHALL carry the byte replicated x4, the half replicated x2, or the word.
REQ-022 Store: on gnt, REQ->IDLE; the store SHALL produce no wb_valid.
REQ-023 Load: on gnt, REQ->RSP. In RSP, dmem_rvalid=1 SHALL move the FSM to IDLE, and wb_valid SHALL pulse in the next cycle with the result.
REQ-024 Load result SHALL be dmem_rdata>>(8*addr[1:0]), then sign-extended (000, 001) or zero-extended (100, 101) from 8/16 bits; LW SHALL pass all 32 bits.
REQ-025 dmem_rvalid SHALL be ignored outside RSP; gnt and rvalid in the same cycle SHALL be treated as gnt only.
REQ-026 The wait counter SHALL clear on entry to REQ and increment each cycle in REQ/RSP.
REQ-027 When the counter reaches MAX_WAIT without the awaited strobe: fault pulse with cause 11, FSM SHALL return to IDLE, dmem_req SHALL drop, and wb_valid SHALL be 0.
REQ-028 Outside REQ, dmem_req SHALL be 0 and dmem_be SHALL be 0000.

Reset
REQ-029 While rst=1: state=IDLE; counter=0; every output SHALL be 0, including stall_o, dmem_req, wb_valid and fault.
REQ-030 Reset mid-access SHALL abandon the access immediately (dmem_req deasserts asynchronously); there SHALL be no replay after reset.

Structure
REQ-031 Package mem_pkg SHALL hold the funct3 encodings, the fault_cause codes and the FSM state enum.
REQ-032 Sub-module lsu_load_ext SHALL be purely combinational and SHALL implement the REQ-024 shift and extension.

Verification
REQ-033 LW at addr 0x100: gnt after 2 cycles, rvalid after 1 more with rdata 0xDEADBEEF -> wb_data=0xDEADBEEF; stall_o high for 4 cycles.
REQ-034 LB at 0x103 with rdata 0x80FF_FFFF -> wb_data=0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-035 SH at 0x102 with wdata 0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x100, no wb_valid.
REQ-036 LW at 0x101, pc 0x40 -> fault=1 with cause 01 and fault_pc=0x40, dmem_req stays 0; funct3=011 load -> cause 10.
REQ-037 MAX_WAIT=4, gnt never asserted -> timeout fault (cause 11) after 4 REQ cycles, then IDLE, stall_o=0.
REQ-038 Assert rst while in RSP -> dmem_req=0 and stall_o=0 immediately; a late rvalid after release produces no wb_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: funct3 size codes, fault causes, LSU FSM states and request-forming helpers
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_ILLEGAL  = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;
  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    return store ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                 : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 2'b00);
  endfunction
  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] off);
    return sz == 2'b00 ? 4'b0001 << off : sz == 2'b01 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  endfunction
  function automatic logic [31:0] wdata_of(input logic [1:0] sz, input logic [31:0] d);
    return sz == 2'b00 ? {4{d[7:0]}} : sz == 2'b01 ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: combinational load alignment; rdata,funct3,off in -> shifted and sign/zero-extended result out
module lsu_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] result
);
  logic [31:0] s;
  always_comb begin
    s = rdata >> {off, 3'b000};
    result = funct3[1] ? s
           : funct3[0] ? {{16{s[15] & ~funct3[2]}}, s[15:0]}
           : {{24{s[7] & ~funct3[2]}}, s[7:0]};
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: RV32I load/store unit; ex_* op in, stall_o upstream hold, dmem_* bus request/response, wb_* result, fault/fault_pc/fault_cause errors
module mem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_pc,
  output logic        stall_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [1:0]  fault_cause
);
  state_t state, state_n;
  logic [7:0] cnt;
  logic [31:0] addr_q, wdata_q, pc_q, ld_data;
  logic [2:0] f3_q;
  logic st_q, accept, is_mem, bad_f3, mis, go, timeout, in_req, ld_done, fault_n;
  assign accept = state == S_IDLE && ex_valid;
  assign is_mem = ex_is_load || ex_is_store;
  assign bad_f3 = !f3_legal(ex_is_store, ex_funct3);
  assign mis = misaligned(ex_funct3[1:0], ex_addr[1:0]);
  assign go = accept && is_mem && !bad_f3 && !mis;
  assign in_req = state == S_REQ;
  assign ld_done = state == S_RSP && dmem_rvalid;
  assign timeout = ((in_req && !dmem_gnt) || (state == S_RSP && !dmem_rvalid)) && cnt == 8'(MAX_WAIT - 1);
  assign fault_n = timeout || (accept && is_mem && (bad_f3 || mis));
  assign stall_o = state != S_IDLE;
  assign dmem_req = in_req;
  assign dmem_we = in_req && st_q;
  assign dmem_addr = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dmem_be = in_req ? be_of(f3_q[1:0], addr_q[1:0]) : 4'b0000;
  assign dmem_wdata = in_req ? wdata_of(f3_q[1:0], wdata_q) : 32'd0;
  lsu_load_ext u_ext (
    .rdata  (dmem_rdata),
    .funct3 (f3_q),
    .off    (addr_q[1:0]),
    .result (ld_data)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  state_n = go ? S_REQ : S_IDLE;
      S_REQ:   state_n = dmem_gnt ? (st_q ? S_IDLE : S_RSP) : timeout ? S_IDLE : S_REQ;
      S_RSP:   state_n = (dmem_rvalid || timeout) ? S_IDLE : S_RSP;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      pc_q <= '0;
      f3_q <= '0;
      st_q <= 1'b0;
      wb_valid <= 1'b0;
      wb_data <= '0;
      wb_pc <= '0;
      fault <= 1'b0;
      fault_pc <= '0;
      fault_cause <= FC_NONE;
    end else begin
      cnt <= state == S_IDLE ? 8'd0 : cnt + 8'd1;
      if (go) begin
        addr_q <= ex_addr;
        wdata_q <= ex_wdata;
        pc_q <= ex_pc;
        f3_q <= ex_funct3;
        st_q <= ex_is_store;
      end
      wb_valid <= (accept && !is_mem) || ld_done;
      wb_data <= ld_done ? ld_data : (accept && !is_mem) ? ex_addr : 32'd0;
      wb_pc <= ld_done ? pc_q : (accept && !is_mem) ? ex_pc : 32'd0;
      fault <= fault_n;
      fault_pc <= timeout ? pc_q : fault_n ? ex_pc : 32'd0;
      fault_cause <= timeout ? FC_TIMEOUT : !fault_n ? FC_NONE : bad_f3 ? FC_ILLEGAL : FC_MISALIGN;
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench for mem_lsu with directed load/store/fault/timeout/reset vectors
module tb_mem_lsu;
  logic clk = 1'b0, rst = 1'b1;
  logic ex_valid = 0, ex_is_load = 0, ex_is_store = 0;
  logic [2:0] ex_funct3 = 0;
  logic [31:0] ex_addr = 0, ex_wdata = 0, ex_pc = 0;
  logic stall_o, dmem_req, dmem_we, dmem_gnt = 0, dmem_rvalid = 0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
  logic [3:0] dmem_be;
  logic wb_valid, fault;
  logic [31:0] wb_data, wb_pc, fault_pc;
  logic [1:0] fault_cause;
  always #5 clk = ~clk;
  mem_lsu #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_pc(ex_pc), .stall_o(stall_o),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_pc(wb_pc), .fault(fault), .fault_pc(fault_pc),
    .fault_cause(fault_cause)
  );
  typedef struct {
    logic is_fault;
    logic [31:0] data;
    logic [31:0] pc;
    logic [1:0] cause;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask
  task automatic expect_wb(input logic [31:0] d, input logic [31:0] pc);
    exp_q.push_back('{1'b0, d, pc, 2'b00});
  endtask
  task automatic expect_fault(input logic [1:0] c, input logic [31:0] pc);
    exp_q.push_back('{1'b1, 32'd0, pc, c});
  endtask
  always @(negedge clk)
    if (wb_valid || fault) begin
      if (exp_q.size() == 0) chk("spurious_output", {30'd0, wb_valid, fault}, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_fault) begin
          chk("fault_flag", {31'd0, fault}, 32'd1);
          chk("fault_cause", {30'd0, fault_cause}, {30'd0, mon_e.cause});
          chk("fault_pc", fault_pc, mon_e.pc);
          chk("fault_no_wb", {31'd0, wb_valid}, 32'd0);
        end else begin
          chk("wb_valid", {31'd0, wb_valid}, 32'd1);
          chk("wb_data", wb_data, mon_e.data);
          chk("wb_pc", wb_pc, mon_e.pc);
          chk("wb_no_fault", {31'd0, fault}, 32'd0);
        end
      end
    end
  task automatic run_op(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                        input int gnt_at, input int rv_at, input logic dup, input logic [31:0] rd,
                        input logic [3:0] be, input logic [31:0] ba, input logic [31:0] bwd,
                        input int want_stall, input int want_req);
    int stalls = 0, reqs = 0;
    ex_valid = 1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_addr = a; ex_wdata = wd; ex_pc = pc;
    @(posedge clk); #1;
    ex_valid = 0;
    for (int c = 1; c <= 10; c++) begin
      dmem_gnt = (c == gnt_at);
      dmem_rvalid = (c == rv_at) || (dup && c == gnt_at);
      dmem_rdata = rd;
      @(negedge clk);
      if (stall_o) stalls++;
      if (dmem_req) reqs++;
      if (c == 1) begin
        chk({nm, "_req"}, {31'd0, dmem_req}, {31'd0, be != 4'd0});
        chk({nm, "_be"}, {28'd0, dmem_be}, {28'd0, be});
        if (be != 4'd0) begin
          chk({nm, "_addr"}, dmem_addr, ba);
          chk({nm, "_wdata"}, dmem_wdata, bwd);
          chk({nm, "_we"}, {31'd0, dmem_we}, {31'd0, st});
        end
      end
      @(posedge clk); #1;
    end
    dmem_gnt = 0; dmem_rvalid = 0;
    chk({nm, "_stalls"}, stalls, want_stall);
    chk({nm, "_reqs"}, reqs, want_req);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stall_o}, 0);
    chk("rst_req", {31'd0, dmem_req}, 0);
    chk("rst_be", {28'd0, dmem_be}, 0);
    chk("rst_wb", {31'd0, wb_valid}, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    expect_wb(32'h1234_5678, 32'h10);
    run_op("alu", 0, 0, 3'b000, 32'h1234_5678, 0, 32'h10, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    expect_wb(32'hDEAD_BEEF, 32'h20);
    run_op("lw", 1, 0, 3'b010, 32'h100, 0, 32'h20, 2, 4, 0, 32'hDEAD_BEEF, 4'b1111, 32'h100, 0, 4, 2);
    expect_wb(32'hFFFF_FF80, 32'h24);
    run_op("lb", 1, 0, 3'b000, 32'h103, 0, 32'h24, 1, 2, 0, 32'h80FF_FFFF, 4'b1000, 32'h100, 0, 2, 1);
    expect_wb(32'h0000_0080, 32'h28);
    run_op("lbu", 1, 0, 3'b100, 32'h103, 0, 32'h28, 1, 2, 0, 32'h80FF_FFFF, 4'b1000, 32'h100, 0, 2, 1);
    expect_wb(32'hFFFF_8001, 32'h2C);
    run_op("lh", 1, 0, 3'b001, 32'h102, 0, 32'h2C, 1, 2, 0, 32'h8001_0000, 4'b1100, 32'h100, 0, 2, 1);
    expect_wb(32'h0000_7FFF, 32'h30);
    run_op("lhu", 1, 0, 3'b101, 32'h102, 0, 32'h30, 1, 2, 0, 32'h7FFF_1234, 4'b1100, 32'h100, 0, 2, 1);
    expect_wb(32'h0000_0055, 32'h34);
    run_op("lw_dup", 1, 0, 3'b010, 32'h204, 0, 32'h34, 1, 3, 1, 32'h0000_0055, 4'b1111, 32'h204, 0, 3, 1);
    run_op("sh", 0, 1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h38, 1, 0, 0, 0, 4'b1100, 32'h100, 32'hABCD_ABCD, 1, 1);
    run_op("sb", 0, 1, 3'b000, 32'h001, 32'h0000_00A5, 32'h3C, 1, 2, 0, 0, 4'b0010, 32'h000, 32'hA5A5_A5A5, 1, 1);
    run_op("sw", 0, 1, 3'b010, 32'h008, 32'hCAFE_F00D, 32'h3E, 2, 0, 0, 0, 4'b1111, 32'h008, 32'hCAFE_F00D, 2, 2);
    expect_fault(2'b01, 32'h40);
    run_op("lw_mis", 1, 0, 3'b010, 32'h101, 0, 32'h40, 1, 2, 0, 0, 4'b0000, 0, 0, 0, 0);
    expect_fault(2'b10, 32'h44);
    run_op("ld_ill", 1, 0, 3'b011, 32'h000, 0, 32'h44, 1, 2, 0, 0, 4'b0000, 0, 0, 0, 0);
    expect_fault(2'b10, 32'h48);
    run_op("st_ill", 0, 1, 3'b100, 32'h000, 0, 32'h48, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    expect_fault(2'b01, 32'h4C);
    run_op("lh_mis", 1, 0, 3'b001, 32'h001, 0, 32'h4C, 1, 2, 0, 0, 4'b0000, 0, 0, 0, 0);
    expect_fault(2'b11, 32'h50);
    run_op("to_req", 1, 0, 3'b010, 32'h300, 0, 32'h50, 0, 0, 0, 0, 4'b1111, 32'h300, 0, 4, 4);
    expect_fault(2'b11, 32'h54);
    run_op("to_rsp", 1, 0, 3'b010, 32'h304, 0, 32'h54, 1, 0, 0, 0, 4'b1111, 32'h304, 0, 4, 1);
    ex_valid = 1; ex_is_load = 1; ex_is_store = 0; ex_funct3 = 3'b010;
    ex_addr = 32'h400; ex_wdata = 0; ex_pc = 32'h60;
    @(posedge clk); #1;
    ex_valid = 0; dmem_gnt = 1;
    @(posedge clk); #1;
    dmem_gnt = 0;
    @(negedge clk);
    chk("rsp_stall", {31'd0, stall_o}, 1);
    #2 rst = 1;
    #1;
    chk("arst_req", {31'd0, dmem_req}, 0);
    chk("arst_stall", {31'd0, stall_o}, 0);
    @(posedge clk); #1;
    rst = 0;
    dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_rvalid_wb", {31'd0, wb_valid}, 0);
      chk("late_rvalid_stall", {31'd0, stall_o}, 0);
    end
    dmem_rvalid = 0;
    repeat (3) @(posedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
